// File: rtl/dp_ram_bist.sv
`default_nettype none
// ============================================================================
//  Module   : dp_ram_bist
//  Purpose  : March C- built-in self-test controller for one dual-port RAM.
//             Drives the RAM write/read ports, compares every read against
//             the expected background and reports pass/fail, the first
//             failing address/data and a saturating mismatch count.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             start              - begin a run (accepted in IDLE or DONE)
//             wr_en/wr_addr/w_data, rd_en/rd_addr/r_data - RAM interface
//             busy, done, pass   - run status
//             fail_addr/fail_data - first mismatch capture
//             err_cnt            - mismatch count, saturates at 255
//  Config   : DP_RAM_BIST_STOP_ON_FAIL_EN - when defined, the first mismatch
//             ends the run immediately and outstanding reads are discarded.
//  Revision : 1.0 - initial release
// ============================================================================
module dp_ram_bist #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [7:0]            err_cnt
);

  localparam logic [1:0]            c_idle       = 2'd0;
  localparam logic [1:0]            c_run        = 2'd1;
  localparam logic [1:0]            c_drain      = 2'd2;
  localparam logic [1:0]            c_done       = 2'd3;
  localparam logic [ADDR_WIDTH-1:0] c_addr_top   = '1;
  localparam logic [2:0]            c_drain_last = 3'(RD_LAT - 1);

  logic [1:0]            r_state, w_state_nxt;
  logic [2:0]            r_elem, w_elem_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic                  r_phase, w_phase_nxt;
  logic [2:0]            r_drain_cnt;

  // Compare pipeline: read-valid, address and expected word travel
  // RD_LAT stages so the last stage lines up with r_data.
  logic                  r_pv [RD_LAT];
  logic [ADDR_WIDTH-1:0] r_pa [RD_LAT];
  logic [DATA_WIDTH-1:0] r_pe [RD_LAT];

  logic                  w_start_ok, w_active, w_mismatch, w_stop, w_last_op;
  logic                  w_two_ops, w_down, w_addr_end;
  logic                  w_op_valid, w_op_rd, w_op_bit;
  logic [7:0]            w_err_nxt;

  // Counters (r_elem, r_addr, r_phase) describe the op on the RAM port now.
  assign w_start_ok = start && (r_state == c_idle || r_state == c_done);
  assign w_active   = (r_state == c_run) || (r_state == c_drain);
  assign w_two_ops  = (r_elem != 3'd0) && (r_elem != 3'd5);
  assign w_down     = (r_elem >= 3'd3);
  assign w_addr_end = w_down ? (r_addr == '0) : (r_addr == c_addr_top);
  assign w_last_op  = (r_elem == 3'd5) && (r_addr == '0);
  assign w_mismatch = w_active && r_pv[RD_LAT-1] && (r_data != r_pe[RD_LAT-1]);

`ifdef DP_RAM_BIST_STOP_ON_FAIL_EN
  assign w_stop = w_mismatch;
`else
  assign w_stop = 1'b0;
`endif

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_idle;
    else     r_state <= w_state_nxt;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:  if (start) w_state_nxt = c_run;
      c_run:   if (w_stop) w_state_nxt = c_done;
               else if (w_last_op) w_state_nxt = c_drain;
      c_drain: if (w_stop || r_drain_cnt == c_drain_last) w_state_nxt = c_done;
      c_done:  if (start) w_state_nxt = c_run;
      default: w_state_nxt = c_idle;
    endcase
  end

  // ---------------- output / sequencer logic ----------------
  // Computes the op for the next cycle so every RAM-side output is a flop.
  always_comb begin
    w_elem_nxt  = r_elem;
    w_addr_nxt  = r_addr;
    w_phase_nxt = r_phase;
    if (w_start_ok) begin
      w_elem_nxt  = 3'd0;
      w_addr_nxt  = '0;
      w_phase_nxt = 1'b0;
    end else if (r_state == c_run) begin
      if (w_two_ops && !r_phase) begin
        w_phase_nxt = 1'b1;
      end else begin
        w_phase_nxt = 1'b0;
        if (w_addr_end) begin
          w_elem_nxt = r_elem + 3'd1;
          // Elements 3..5 walk downward, so they start at the top address.
          w_addr_nxt = (r_elem >= 3'd2) ? c_addr_top : '0;
        end else begin
          w_addr_nxt = w_down ? (r_addr - 1'b1) : (r_addr + 1'b1);
        end
      end
    end
    w_op_valid = (w_state_nxt == c_run);
    w_op_rd    = (w_elem_nxt == 3'd5) || ((w_elem_nxt != 3'd0) && !w_phase_nxt);
    // Reads expect ones in M2/M4; writes store ones in M1/M3.
    w_op_bit   = w_op_rd ? ((w_elem_nxt == 3'd2) || (w_elem_nxt == 3'd4))
                         : ((w_elem_nxt == 3'd1) || (w_elem_nxt == 3'd3));
    if (w_start_ok)
      w_err_nxt = 8'd0;
    else if (w_mismatch && err_cnt != 8'hFF)
      w_err_nxt = err_cnt + 8'd1;
    else
      w_err_nxt = err_cnt;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_elem      <= 3'd0;
      r_addr      <= '0;
      r_phase     <= 1'b0;
      r_drain_cnt <= 3'd0;
      wr_en       <= 1'b0;
      rd_en       <= 1'b0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      w_data      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_addr   <= '0;
      fail_data   <= '0;
      err_cnt     <= 8'd0;
    end else begin
      r_elem      <= w_elem_nxt;
      r_addr      <= w_addr_nxt;
      r_phase     <= w_phase_nxt;
      r_drain_cnt <= (r_state == c_drain) ? (r_drain_cnt + 3'd1) : 3'd0;
      wr_en       <= w_op_valid && !w_op_rd;
      rd_en       <= w_op_valid && w_op_rd;
      if (w_op_valid) begin
        wr_addr <= w_addr_nxt;
        rd_addr <= w_addr_nxt;
        w_data  <= {DATA_WIDTH{w_op_bit}};
      end
      busy    <= (w_state_nxt == c_run) || (w_state_nxt == c_drain);
      done    <= (w_state_nxt == c_done);
      err_cnt <= w_err_nxt;
      if (w_start_ok) begin
        pass      <= 1'b0;
        fail_addr <= '0;
        fail_data <= '0;
      end else begin
        if (w_mismatch && err_cnt == 8'd0) begin
          fail_addr <= r_pa[RD_LAT-1];
          fail_data <= r_data;
        end
        // Uses the post-update count so a mismatch on the final compare counts.
        if (w_state_nxt == c_done && r_state != c_done)
          pass <= (w_err_nxt == 8'd0);
      end
    end
  end

  // ---------------- compare pipeline ----------------
  always_ff @(posedge clk) begin
    if (rst || w_start_ok || w_stop) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pa[i] <= '0;
        r_pe[i] <= '0;
      end
    end else begin
      // During a read, w_data carries the expected background word.
      r_pv[0] <= rd_en;
      r_pa[0] <= rd_addr;
      r_pe[0] <= w_data;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pa[i] <= r_pa[i-1];
        r_pe[i] <= r_pe[i-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dp_ram_bist.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dp_ram_bist
//  Purpose  : Self-checking bench for dp_ram_bist (ADDR_WIDTH=4,
//             DATA_WIDTH=8, RD_LAT=1) with a behavioural RAM that can
//             model word 5 bit 0 stuck-at-1. Expected RAM ops are queued
//             from an independent March C- model and popped as issued.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dp_ram_bist;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst, start;
  logic          wr_en, rd_en, busy, done, pass;
  logic [AW-1:0] wr_addr, rd_addr, fail_addr;
  logic [DW-1:0] w_data, r_data, fail_data;
  logic [7:0]    err_cnt;

  always #5 clk = ~clk;

  dp_ram_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .wr_en(wr_en), .wr_addr(wr_addr), .w_data(w_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .r_data(r_data),
    .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_data(fail_data), .err_cnt(err_cnt)
  );

  // Behavioural RAM, one-cycle read latency, optional stuck-at-1 fault.
  logic [DW-1:0] mem [N];
  logic          fault_on;
  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= w_data;
    if (rd_en) r_data <= mem[rd_addr] | ((fault_on && rd_addr == 4'd5) ? 8'h01 : 8'h00);
  end

  int          n_cmp, n_bad, n_ops;
  logic        mon_en;
  logic [31:0] exp_q[$];
  logic [31:0] mon_got, mon_want;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [31:0] opw(input bit wr, input int a, input logic [7:0] d);
    logic [3:0] a4;
    a4 = a[3:0];
    return {18'd0, wr, ~wr, a4, (wr ? d : 8'h00)};
  endfunction

  // Reference March C- op stream.
  task automatic push_march();
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        int a;
        a = (e >= 3) ? (N - 1 - i) : i;
        case (e)
          0: exp_q.push_back(opw(1'b1, a, 8'h00));
          1: begin exp_q.push_back(opw(1'b0, a, 8'h00)); exp_q.push_back(opw(1'b1, a, 8'hFF)); end
          2: begin exp_q.push_back(opw(1'b0, a, 8'h00)); exp_q.push_back(opw(1'b1, a, 8'h00)); end
          3: begin exp_q.push_back(opw(1'b0, a, 8'h00)); exp_q.push_back(opw(1'b1, a, 8'hFF)); end
          4: begin exp_q.push_back(opw(1'b0, a, 8'h00)); exp_q.push_back(opw(1'b1, a, 8'h00)); end
          default: exp_q.push_back(opw(1'b0, a, 8'h00));
        endcase
      end
    end
  endtask

  // Op monitor: every issued RAM op is popped from the scoreboard.
  always @(negedge clk) begin
    if (mon_en && (wr_en || rd_en)) begin
      mon_got = {18'd0, wr_en, rd_en, (wr_en ? wr_addr : rd_addr), (wr_en ? w_data : 8'h00)};
      n_ops++;
      if (exp_q.size() == 0) mon_want = 32'hFFFF_FFFF;
      else                   mon_want = exp_q.pop_front();
      chk("op", mon_got, mon_want);
    end
  end

  task automatic run_bist(input bit flt, input int repulse_at, input int exp_busy,
                          input int exp_ops, input bit exp_pass, input logic [7:0] exp_err,
                          input logic [3:0] exp_fa, input logic [7:0] exp_fd);
    int busy_cyc;
    int guard;
    fault_on = flt;
    exp_q.delete();
    push_march();
    n_ops  = 0;
    mon_en = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    // First cycle after the accepted start.
    chk("t1_busy", busy, 1);
    chk("t1_wr", {wr_en, rd_en, wr_addr}, {1'b1, 1'b0, 4'd0});
    chk("t1_done_clr", done, 0);
    chk("t1_err_clr", err_cnt, 0);
    chk("t1_fail_clr", {pass, fail_addr, fail_data}, 0);
    busy_cyc = 1;
    guard    = 0;
    while (!done && guard < 400) begin
      @(negedge clk);
      guard++;
      start = (repulse_at > 0 && busy_cyc == repulse_at);
      if (busy) busy_cyc++;
    end
    start = 1'b0;
    chk("done", done, 1);
    chk("busy_at_done", busy, 0);
    chk("busy_cycles", busy_cyc, exp_busy);
    chk("pass", pass, exp_pass);
    chk("err_cnt", err_cnt, exp_err);
    chk("fail_addr", fail_addr, exp_fa);
    chk("fail_data", fail_data, exp_fd);
    chk("op_count", n_ops, exp_ops);
    chk("q_left", exp_q.size(), 160 - exp_ops);
    mon_en = 1'b0;
    @(negedge clk);
    chk("done_hold", done, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; fault_on = 1'b0; mon_en = 1'b0;
    n_cmp = 0; n_bad = 0; n_ops = 0;
    for (int i = 0; i < N; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_en", {wr_en, rd_en}, 0);
    chk("rst_addr", {wr_addr, rd_addr}, 0);
    chk("rst_wdata", w_data, 0);
    chk("rst_status", {busy, done, pass}, 0);
    chk("rst_fail", {fail_addr, fail_data}, 0);
    chk("rst_err", err_cnt, 0);
    rst = 1'b0;

    // Fault-free run.
    run_bist(1'b0, 0, 161, 160, 1'b1, 8'd0, 4'd0, 8'h00);

    // Word 5 bit 0 stuck-at-1.
`ifdef DP_RAM_BIST_STOP_ON_FAIL_EN
    run_bist(1'b1, 0, 28, 28, 1'b0, 8'd1, 4'd5, 8'h01);
`else
    run_bist(1'b1, 0, 161, 160, 1'b0, 8'd3, 4'd5, 8'h01);
`endif

    // Start from DONE clears results; a start re-pulse mid-run is ignored.
    run_bist(1'b0, 30, 161, 160, 1'b1, 8'd0, 4'd0, 8'h00);

    // Reset during op cycle 50.
    fault_on = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (49) @(negedge clk);
    chk("op50_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_en", {wr_en, rd_en}, 0);
    chk("midrst_status", {busy, done}, 0);
    chk("midrst_err", err_cnt, 0);
    rst = 1'b0;
    run_bist(1'b0, 0, 161, 160, 1'b1, 8'd0, 4'd0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
